// File: rtl/array_stim_gen.sv
// Multi-channel lockstep burst generator (CONST/INCR/XORSHIFT/WALK1) for array bring-up and BIST.
// Optional XOR signature accumulation is built only when STIM_SIGNATURE_EN is defined.
module array_stim_gen #(
  parameter int N_CH   = 8,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic                     abort,
  input  logic [1:0]               cfg_mode,
  input  logic [LEN_W-1:0]         cfg_len,
  input  logic [DATA_W-1:0]        cfg_seed,
  input  logic                     cfg_bcast,
  input  logic [N_CH-1:0]          ch_ready,
  output logic [N_CH-1:0]          ch_valid,
  output logic [N_CH*DATA_W-1:0]   ch_data,
  output logic                     busy,
  output logic                     done,
  output logic [LEN_W-1:0]         beat_cnt,
  output logic [DATA_W-1:0]        signature,
  output logic [1:0]               dbg_state
);

  // Handshake: a beat transfers on a clock edge where ch_valid is high and every
  // ch_ready bit is high; until then ch_data and ch_valid stay frozen. ch_valid is
  // driven from state only, so there is no combinational path from ch_ready.

  localparam logic [1:0] MODE_CONST    = 2'd0;
  localparam logic [1:0] MODE_INCR     = 2'd1;
  localparam logic [1:0] MODE_XORSHIFT = 2'd2;
  localparam logic [1:0] MODE_WALK1    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        mode_q;
  logic [LEN_W-1:0]  len_q;
  logic              load;
  logic              accept;
  logic              last_beat;

  function automatic logic [DATA_W-1:0] xorshift(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] y;
    y = x;
    y = y ^ (y << 13);
    y = y ^ (y >> 7);
    y = y ^ (y << 17);
    return y;
  endfunction

  function automatic logic [DATA_W-1:0] next_beat(input logic [1:0] mode,
                                                  input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] y;
    y = x;
    case (mode)
      MODE_INCR:     y = x + 1'b1;
      MODE_XORSHIFT: y = xorshift(x);
      MODE_WALK1:    y = {x[DATA_W-2:0], x[DATA_W-1]};
      default:       y = x;
    endcase
    return y;
  endfunction

  assign load      = (state_q == S_IDLE) && start;
  assign accept    = (state_q == S_RUN) && (&ch_ready);
  assign last_beat = (beat_cnt == (len_q - 1'b1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = (cfg_len == '0) ? S_DONE : S_RUN;
      S_RUN: begin
        if (abort)                      state_d = S_IDLE;
        else if (accept && last_beat)   state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      mode_q   <= MODE_CONST;
      len_q    <= '0;
      beat_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        mode_q   <= cfg_mode;
        len_q    <= cfg_len;
        beat_cnt <= '0;
      end else if (accept) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  assign ch_valid  = {N_CH{state_q == S_RUN}};
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign dbg_state = state_q;

  // Each channel register holds the beat currently presented and advances on accept.
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    localparam int ROT = c % DATA_W;
    logic [DATA_W-1:0] seed_rot;
    logic [DATA_W-1:0] seed_c;
    logic [DATA_W-1:0] init_c;
    logic [DATA_W-1:0] data_q;

    if (ROT == 0) begin : g_r0
      assign seed_rot = cfg_seed;
    end else begin : g_rn
      assign seed_rot = {cfg_seed[DATA_W-1-ROT:0], cfg_seed[DATA_W-1:DATA_W-ROT]};
    end

    assign seed_c = cfg_bcast ? cfg_seed : seed_rot;

    always_comb begin
      init_c = seed_c;
      case (cfg_mode)
        MODE_XORSHIFT: init_c = (seed_c == '0) ? '1 : seed_c;
        MODE_WALK1:    init_c = {{(DATA_W-1){1'b0}}, 1'b1} << ROT;
        default:       init_c = seed_c;
      endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)       data_q <= '0;
      else if (load)   data_q <= init_c;
      else if (accept) data_q <= next_beat(mode_q, data_q);
    end

    assign ch_data[c*DATA_W +: DATA_W] = data_q;
  end

`ifdef STIM_SIGNATURE_EN
  logic [DATA_W-1:0] beat_xor;

  always_comb begin
    beat_xor = '0;
    for (int c = 0; c < N_CH; c++) beat_xor = beat_xor ^ ch_data[c*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       signature <= '0;
    else if (load)   signature <= '0;
    else if (accept) signature <= signature ^ beat_xor;
  end
`else
  assign signature = '0;
`endif

endmodule

// File: tb/tb_array_stim_gen.sv
// Randomized scoreboard bench for array_stim_gen: a reference model fills an expected
// queue per burst and a negedge monitor pops and compares every accepted beat.
module tb_array_stim_gen;
  localparam int N_CH   = 8;
  localparam int DATA_W = 64;
  localparam int LEN_W  = 16;
  localparam int VW     = N_CH * DATA_W;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic [1:0]          cfg_mode = '0;
  logic [LEN_W-1:0]    cfg_len = '0;
  logic [DATA_W-1:0]   cfg_seed = '0;
  logic                cfg_bcast = 1'b0;
  logic [N_CH-1:0]     ch_ready = '1;
  logic [N_CH-1:0]     ch_valid;
  logic [VW-1:0]       ch_data;
  logic                busy;
  logic                done;
  logic [LEN_W-1:0]    beat_cnt;
  logic [DATA_W-1:0]   signature;
  logic [1:0]          dbg_state;

  array_stim_gen #(.N_CH(N_CH), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .cfg_mode(cfg_mode), .cfg_len(cfg_len), .cfg_seed(cfg_seed), .cfg_bcast(cfg_bcast),
    .ch_ready(ch_ready), .ch_valid(ch_valid), .ch_data(ch_data),
    .busy(busy), .done(done), .beat_cnt(beat_cnt), .signature(signature),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- scoreboard state ----------------
  logic [VW-1:0]     exp_q[$];
  logic [DATA_W-1:0] sig_model;
  int tests = 0;
  int fails = 0;
  int valid_cyc = 0;
  int done_cnt = 0;
  int last_acc_cyc = 0;
  bit zero_len = 1'b0;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] x, input int r);
    int k;
    k = r % DATA_W;
    if (k == 0) return x;
    return (x << k) | (x >> (DATA_W - k));
  endfunction

  function automatic logic [DATA_W-1:0] model_beat(input logic [1:0] mode,
      input logic [DATA_W-1:0] seed, input logic bcast, input int c, input int n);
    logic [DATA_W-1:0] s;
    logic [DATA_W-1:0] x;
    s = bcast ? seed : rotl(seed, c);
    case (mode)
      2'd0: x = s;
      2'd1: x = s + DATA_W'(n);
      2'd2: begin
        x = (s == '0) ? '1 : s;
        for (int i = 0; i < n; i++) begin
          x = x ^ (x << 13);
          x = x ^ (x >> 7);
          x = x ^ (x << 17);
        end
      end
      default: begin
        x = '0;
        x[(n + c) % DATA_W] = 1'b1;
      end
    endcase
    return x;
  endfunction

  function automatic logic [DATA_W-1:0] fold(input logic [VW-1:0] v);
    logic [DATA_W-1:0] f;
    f = '0;
    for (int c = 0; c < N_CH; c++) f = f ^ v[c*DATA_W +: DATA_W];
    return f;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    logic [VW-1:0] held_data;
    logic [VW-1:0] e;
    bit held;
    held = 1'b0;
    held_data = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        held = 1'b0;
      end else begin
        check("valid_uniform", VW'(ch_valid == '0 || ch_valid == '1), VW'(1));
        if (ch_valid[0]) begin
          valid_cyc++;
          if (held) check("stall_hold", ch_data, held_data);
          if (&ch_ready) begin
            if (exp_q.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL unexpected_beat: got %0h expected no beat", ch_data);
            end else begin
              e = exp_q.pop_front();
              check("beat_data", ch_data, e);
              sig_model = sig_model ^ fold(e);
            end
            last_acc_cyc = cyc;
            held = 1'b0;
          end else begin
            held = 1'b1;
            held_data = ch_data;
          end
        end else begin
          held = 1'b0;
        end
        if (done) begin
          done_cnt++;
          check("done_no_valid", VW'(ch_valid), VW'(0));
          if (!zero_len) check("done_latency", VW'(cyc - last_acc_cyc), VW'(1));
        end
      end
    end
  end

  // ---------------- driver ----------------
  // rdy_kind: 0 all ready, 1 random ready plus stray start noise, 2 ch_ready[2] low in burst cycles 2..5
  task automatic run_burst(input logic [1:0] mode, input int len, input logic [DATA_W-1:0] seed,
                           input logic bcast, input int rdy_kind, input int abort_at,
                           input bit abort_acc);
    logic [VW-1:0] e;
    logic [DATA_W-1:0] exp_sig;
    int bc;
    int d0;
    int exp_bc;
    bit aborted;
    for (int n = 0; n < len; n++) begin
      for (int c = 0; c < N_CH; c++) e[c*DATA_W +: DATA_W] = model_beat(mode, seed, bcast, c, n);
      exp_q.push_back(e);
    end
    sig_model = '0;
    valid_cyc = 0;
    zero_len = (len == 0);
    d0 = done_cnt;
    aborted = 1'b0;

    @(posedge clk); #1;
    cfg_mode = mode;
    cfg_len = LEN_W'(len);
    cfg_seed = seed;
    cfg_bcast = bcast;
    ch_ready = '1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_mode = 2'($urandom_range(0, 3));
    cfg_len = LEN_W'($urandom_range(0, 20));
    cfg_seed = {$urandom, $urandom};
    cfg_bcast = 1'($urandom_range(0, 1));

    bc = 0;
    while (busy && bc < 500) begin
      case (rdy_kind)
        1: begin
          for (int c = 0; c < N_CH; c++) ch_ready[c] = ($urandom_range(0, 7) != 0);
          start = ($urandom_range(0, 5) == 0);
        end
        2: begin
          ch_ready = '1;
          if (bc >= 2 && bc <= 5) ch_ready[2] = 1'b0;
        end
        default: ch_ready = '1;
      endcase
      if (abort_at >= 0 && dbg_state == 2'd1 && int'(beat_cnt) == abort_at) begin
        abort = 1'b1;
        aborted = 1'b1;
        ch_ready = abort_acc ? '1 : '0;
      end
      @(posedge clk); #1;
      abort = 1'b0;
      start = 1'b0;
      bc++;
    end
    start = 1'b0;
    ch_ready = '1;
    if (bc >= 500) begin
      tests++;
      fails++;
      $display("FAIL burst_timeout: got busy after %0d cycles expected idle", bc);
    end
    if (aborted) check("abort_valid_drop", VW'(ch_valid), VW'(0));

    exp_bc = aborted ? abort_at + (abort_acc ? 1 : 0) : len;
    repeat (2) @(posedge clk);
    #1;
    check("beat_cnt", VW'(beat_cnt), VW'(exp_bc));
    check("done_pulses", VW'(done_cnt - d0), VW'(aborted ? 0 : 1));
    check("leftover_beats", VW'(exp_q.size()), VW'(len - exp_bc));
    exp_q.delete();
    if (rdy_kind == 0 && !aborted) check("valid_cycles", VW'(valid_cyc), VW'(len));
`ifdef STIM_SIGNATURE_EN
    exp_sig = sig_model;
`else
    exp_sig = '0;
`endif
    check("signature", VW'(signature), VW'(exp_sig));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", VW'(ch_valid), VW'(0));
    check("rst_data", ch_data, VW'(0));
    check("rst_flags", VW'({busy, done}), VW'(0));
    check("rst_beat_cnt", VW'(beat_cnt), VW'(0));
    check("rst_signature", VW'(signature), VW'(0));
    @(posedge clk); #2;
    rstn = 1'b1;

    run_burst(2'd1, 4, 64'h10, 1'b1, 0, -1, 1'b0);
    run_burst(2'd0, 3, {$urandom, $urandom}, 1'b1, 2, -1, 1'b0);
    run_burst(2'd2, 2, 64'h0, 1'b0, 0, -1, 1'b0);
    run_burst(2'd2, 3, 64'hDEAD_BEEF_0123_4567, 1'b0, 0, -1, 1'b0);
    run_burst(2'd3, 3, {$urandom, $urandom}, 1'b0, 0, -1, 1'b0);
    run_burst(2'd0, 1, 64'hA5, 1'b1, 0, -1, 1'b0);
    run_burst(2'd1, 0, 64'h55, 1'b1, 0, -1, 1'b0);
    run_burst(2'd1, 10, 64'h100, 1'b0, 0, 5, 1'b0);
    run_burst(2'd3, 10, 64'h0, 1'b1, 0, 5, 1'b1);

    for (int t = 0; t < 25; t++) begin
      run_burst(2'($urandom_range(0, 3)), $urandom_range(1, 12), {$urandom, $urandom},
                1'($urandom_range(0, 1)), 1, -1, 1'b0);
    end

    // asynchronous reset in the middle of a running burst
    begin
      logic [VW-1:0] e;
      for (int n = 0; n < 10; n++) begin
        for (int c = 0; c < N_CH; c++) e[c*DATA_W +: DATA_W] = model_beat(2'd1, 64'h77, 1'b0, c, n);
        exp_q.push_back(e);
      end
      zero_len = 1'b0;
      @(posedge clk); #1;
      cfg_mode = 2'd1;
      cfg_len = LEN_W'(10);
      cfg_seed = 64'h77;
      cfg_bcast = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      rstn = 1'b0;
      #1;
      check("midrst_valid", VW'(ch_valid), VW'(0));
      check("midrst_data", ch_data, VW'(0));
      check("midrst_flags", VW'({busy, done}), VW'(0));
      check("midrst_beat_cnt", VW'(beat_cnt), VW'(0));
      check("midrst_signature", VW'(signature), VW'(0));
      exp_q.delete();
      @(posedge clk); #2;
      rstn = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("post_rst_idle", VW'({busy, ch_valid}), VW'(0));
    end

    run_burst(2'd1, 5, {$urandom, $urandom}, 1'b1, 1, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
